// File: rtl/biquad_iir_mc_if.sv
// biquad_iir_mc_if: sample, coefficient and result signals of the multi-channel biquad
interface biquad_iir_mc_if #(parameter int W = 25, parameter int NCH = 4);
  localparam int CHW = $clog2(NCH);
  logic in_valid, in_ready, coef_we, out_valid, sat;
  logic [CHW-1:0] in_ch, out_ch;
  logic signed [W-1:0] u, coef_data, y;
  logic [2:0] coef_addr;
  modport master (output in_valid, in_ch, u, coef_we, coef_addr, coef_data,
                  input in_ready, out_valid, out_ch, y, sat);
  modport slave (input in_valid, in_ch, u, coef_we, coef_addr, coef_data,
                 output in_ready, out_valid, out_ch, y, sat);
endinterface

// File: rtl/biquad_iir_mc.sv
// biquad_iir_mc: time-multiplexed multi-channel direct-form-II biquad with one shared MAC
// BIQUAD_SAT_EN selects saturating accumulator and quantiser instead of wrap-around.
module biquad_iir_mc #(parameter int W = 25, parameter int FRAC = 12, parameter int NCH = 4) (
  input logic clk,
  input logic rst,
  input logic enable,
  biquad_iir_mc_if.slave b
);
  localparam int CHW = $clog2(NCH);
  localparam int AW = 2*W+3;
  typedef enum logic [2:0] {IDLE, A1, A2, SW, B0, B1, B2, SOUT} state_t;
  state_t st, st_n;
  logic signed [W-1:0] shd [5], act [5], shd_n [5];
  logic signed [W-1:0] w1 [NCH], w2 [NCH];
  logic signed [W-1:0] w_reg, cf, op, q;
  logic signed [AW-1:0] acc, acc_n;
  logic signed [2*W-1:0] prod;
  logic [CHW-1:0] ch;
  logic accept;
`ifdef BIQUAD_SAT_EN
  logic signed [AW:0] sum;
  logic signed [AW-1:0] sh;
  logic qs, w_sat;
`endif
  assign b.in_ready = enable & (st == IDLE);
  assign accept = b.in_valid & b.in_ready;
  always_comb begin
    st_n = st == IDLE ? (accept ? A1 : IDLE) : st == SOUT ? IDLE : state_t'(st + 3'd1);
    cf = st == A1 ? act[3] : st == A2 ? act[4] : st == B0 ? act[0] : st == B1 ? act[1] : act[2];
    op = (st == A1 || st == B1) ? w1[ch] : (st == A2 || st == B2) ? w2[ch] : w_reg;
    prod = cf * op;
    for (int i = 0; i < 5; i++)
      shd_n[i] = (enable && b.coef_we && b.coef_addr == 3'(i)) ? b.coef_data : shd[i];
`ifdef BIQUAD_SAT_EN
    sum = acc + prod;
    acc_n = sum[AW] != sum[AW-1] ? (sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}}) : sum[AW-1:0];
    sh = acc >>> FRAC;
    // overflow when the bits above the W-bit sign position disagree
    qs = !(&sh[AW-1:W-1]) && (|sh[AW-1:W-1]);
    q = qs ? (sh[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sh[W-1:0];
`else
    acc_n = acc + prod;
    q = acc[W-1+FRAC:FRAC];
`endif
  end
  always_ff @(posedge clk) begin
    b.out_valid <= !rst && enable && st == SOUT;
    if (rst) begin
      st <= IDLE;
      acc <= '0;
      w_reg <= '0;
      ch <= '0;
      b.y <= '0;
      b.out_ch <= '0;
      b.sat <= 1'b0;
`ifdef BIQUAD_SAT_EN
      w_sat <= 1'b0;
`endif
      for (int i = 0; i < 5; i++) begin
        shd[i] <= i == 0 ? W'(1 << FRAC) : '0;
        act[i] <= i == 0 ? W'(1 << FRAC) : '0;
      end
      for (int i = 0; i < NCH; i++) begin
        w1[i] <= '0;
        w2[i] <= '0;
      end
    end else if (enable) begin
      st <= st_n;
      shd <= shd_n;
      if (accept) begin
        act <= shd_n;
        ch <= b.in_ch;
        acc <= AW'(b.u) <<< FRAC;
      end else if (st == SW) begin
        w_reg <= q;
        acc <= '0;
`ifdef BIQUAD_SAT_EN
        w_sat <= qs;
`endif
      end else if (st == SOUT) begin
        b.y <= q;
        b.out_ch <= ch;
`ifdef BIQUAD_SAT_EN
        b.sat <= w_sat | qs;
`endif
        w1[ch] <= w_reg;
        w2[ch] <= w1[ch];
      end else if (st != IDLE) acc <= acc_n;
    end
  end
endmodule

// File: tb/tb_biquad_iir_mc.sv
// tb_biquad_iir_mc: directed self-checking bench for the multi-channel biquad
module tb_biquad_iir_mc;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1;
  int checks = 0, errors = 0;
  biquad_iir_mc_if #(.W(25), .NCH(4)) bi();
  biquad_iir_mc #(.W(25), .FRAC(12), .NCH(4)) dut (.clk(clk), .rst(rst), .enable(enable), .b(bi));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bi.in_valid = 1'b0;
    bi.coef_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic wcoef(input logic [2:0] a, input logic signed [24:0] d);
    bi.coef_we = 1'b1;
    bi.coef_addr = a;
    bi.coef_data = d;
    tick();
    bi.coef_we = 1'b0;
  endtask
  task automatic send(input logic [1:0] c, input logic signed [24:0] v);
    int n = 0;
    while (!bi.in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!bi.in_ready) begin
      errors++;
      $display("FAIL send_ready in_ready=%0b required 1", bi.in_ready);
    end
    bi.in_valid = 1'b1;
    bi.in_ch = c;
    bi.u = v;
    tick();
    bi.in_valid = 1'b0;
  endtask
  task automatic get(output logic signed [24:0] yo, output logic [1:0] co, output logic so, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bi.out_valid && lat < 20);
    checks++;
    if (!bi.out_valid) begin
      errors++;
      lat = 99;
      $display("FAIL out_timeout out_valid=0 required 1 within 20 cycles");
    end
    yo = bi.y;
    co = bi.out_ch;
    so = bi.sat;
  endtask
  task automatic test_reset();
    logic signed [24:0] yo;
    logic [1:0] co;
    logic so;
    int lat;
    do_reset();
    checks++; if (bi.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b required 0", bi.out_valid); end
    checks++; if (bi.y !== 25'sd0) begin errors++; $display("FAIL rst_y got %0d required 0", bi.y); end
    checks++; if (bi.out_ch !== 2'd0 || bi.sat !== 1'b0) begin errors++; $display("FAIL rst_ch_sat got %0d/%0b required 0/0", bi.out_ch, bi.sat); end
    checks++; if (bi.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b required 1", bi.in_ready); end
    send(2'd0, 25'sd1000);
    get(yo, co, so, lat);
    checks++; if (yo !== 25'sd1000 || co !== 2'd0) begin errors++; $display("FAIL def_ch0 got y=%0d ch=%0d required 1000/0", yo, co); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL latency got %0d required 7", lat); end
    tick();
    checks++; if (bi.out_valid !== 1'b0 || bi.y !== 25'sd1000) begin errors++; $display("FAIL pulse_hold got v=%0b y=%0d required 0/1000", bi.out_valid, bi.y); end
    send(2'd3, -25'sd5);
    get(yo, co, so, lat);
    checks++; if (yo !== -25'sd5 || co !== 2'd3) begin errors++; $display("FAIL def_ch3 got y=%0d ch=%0d required -5/3", yo, co); end
  endtask
  task automatic test_fir();
    logic signed [24:0] yo;
    logic [1:0] co;
    logic so;
    int lat;
    int uin [3] = '{4096, 0, 0};
    int exp_y [3] = '{2048, 2048, 0};
    do_reset();
    wcoef(3'd0, 25'sd2048);
    wcoef(3'd1, 25'sd2048);
    for (int k = 0; k < 3; k++) begin
      send(2'd1, 25'(uin[k]));
      get(yo, co, so, lat);
      checks++; if (yo !== 25'(exp_y[k]) || co !== 2'd1) begin errors++; $display("FAIL fir_%0d got y=%0d ch=%0d required %0d/1", k, yo, co, exp_y[k]); end
    end
    send(2'd2, 25'sd100);
    get(yo, co, so, lat);
    checks++; if (yo !== 25'sd50 || co !== 2'd2) begin errors++; $display("FAIL fir_ch2 got y=%0d ch=%0d required 50/2", yo, co); end
  endtask
  task automatic test_feedback();
    logic signed [24:0] yo;
    logic [1:0] co;
    logic so;
    int lat;
    do_reset();
    wcoef(3'd0, 25'sd4096);
    wcoef(3'd3, 25'sd2048);
    for (int k = 0; k < 4; k++) begin
      send(2'd0, k == 0 ? 25'sd4096 : 25'sd0);
      get(yo, co, so, lat);
      checks++; if (yo !== 25'(4096 >> k)) begin errors++; $display("FAIL fb_%0d got %0d required %0d", k, yo, 4096 >> k); end
      send(2'd1, 25'sd0);
      get(yo, co, so, lat);
      checks++; if (yo !== 25'sd0 || co !== 2'd1) begin errors++; $display("FAIL fb_ch1_%0d got y=%0d ch=%0d required 0/1", k, yo, co); end
    end
  endtask
  task automatic test_sat();
    logic signed [24:0] yo;
    logic [1:0] co;
    logic so;
    int lat;
    do_reset();
    wcoef(3'd0, 25'sd8192);
    send(2'd0, 25'sd16777215);
    get(yo, co, so, lat);
`ifdef BIQUAD_SAT_EN
    checks++; if (yo !== 25'sd16777215 || so !== 1'b1) begin errors++; $display("FAIL sat got y=%0d sat=%0b required 16777215/1", yo, so); end
`else
    checks++; if (yo !== -25'sd2 || so !== 1'b0) begin errors++; $display("FAIL wrap got y=%0d sat=%0b required -2/0", yo, so); end
`endif
  endtask
  task automatic test_reset_mid();
    logic signed [24:0] yo;
    logic [1:0] co;
    logic so;
    int lat, seen;
    do_reset();
    wcoef(3'd0, 25'sd8192);
    send(2'd0, 25'sd500);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bi.in_ready !== 1'b1 || bi.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ready got r=%0b v=%0b required 1/0", bi.in_ready, bi.out_valid); end
    seen = 0;
    repeat (10) begin
      tick();
      if (bi.out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_drop got %0d strobes required 0", seen); end
    send(2'd0, 25'sd7);
    get(yo, co, so, lat);
    checks++; if (yo !== 25'sd7) begin errors++; $display("FAIL midrst_next got %0d required 7", yo); end
  endtask
  task automatic test_coef_midflight();
    logic signed [24:0] yo;
    logic [1:0] co;
    logic so;
    int lat;
    do_reset();
    send(2'd0, 25'sd300);
    tick();
    wcoef(3'd0, 25'sd0);
    get(yo, co, so, lat);
    checks++; if (yo !== 25'sd300) begin errors++; $display("FAIL mid_old got %0d required 300", yo); end
    send(2'd0, 25'sd300);
    get(yo, co, so, lat);
    checks++; if (yo !== 25'sd0) begin errors++; $display("FAIL mid_new got %0d required 0", yo); end
  endtask
  task automatic test_write_through();
    logic signed [24:0] yo;
    logic [1:0] co;
    logic so;
    int lat;
    do_reset();
    bi.in_valid = 1'b1;
    bi.in_ch = 2'd2;
    bi.u = 25'sd10;
    bi.coef_we = 1'b1;
    bi.coef_addr = 3'd0;
    bi.coef_data = 25'sd8192;
    tick();
    bi.in_valid = 1'b0;
    bi.coef_we = 1'b0;
    get(yo, co, so, lat);
    checks++; if (yo !== 25'sd20 || co !== 2'd2) begin errors++; $display("FAIL wthru got y=%0d ch=%0d required 20/2", yo, co); end
  endtask
  task automatic test_enable();
    logic signed [24:0] yo;
    logic [1:0] co;
    logic so;
    int lat, seen;
    do_reset();
    send(2'd1, 25'sd50);
    enable = 1'b0;
    bi.coef_we = 1'b1;
    bi.coef_addr = 3'd0;
    bi.coef_data = 25'sd0;
    seen = 0;
    repeat (8) begin
      tick();
      if (bi.out_valid || bi.in_ready) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL en_freeze got %0d active cycles required 0", seen); end
    enable = 1'b1;
    bi.coef_we = 1'b0;
    get(yo, co, so, lat);
    checks++; if (yo !== 25'sd50 || lat !== 7) begin errors++; $display("FAIL en_resume got y=%0d lat=%0d required 50/7", yo, lat); end
    send(2'd2, 25'sd40);
    get(yo, co, so, lat);
    checks++; if (yo !== 25'sd40) begin errors++; $display("FAIL en_coef_ignored got %0d required 40", yo); end
  endtask
  initial begin
    bi.in_valid = 1'b0;
    bi.in_ch = '0;
    bi.u = '0;
    bi.coef_we = 1'b0;
    bi.coef_addr = '0;
    bi.coef_data = '0;
    test_reset();
    test_fir();
    test_feedback();
    test_sat();
    test_reset_mid();
    test_coef_midflight();
    test_write_through();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
